// File: rtl/brightness_pkg.sv
// Shared definitions for the brightness coefficient sequencer.
// Contents:
//   state_t         - sequencer state (idle / ramping)
//   COE_WIDTH_DEF   - default coefficient width (matches filter coe_i)
//   COE_UNITY_DEF   - default reset/unity coefficient value
//   coe_t           - coefficient word at the default width
package brightness_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    localparam int COE_WIDTH_DEF = 16;
    localparam int COE_UNITY_DEF = 128;

    typedef logic [COE_WIDTH_DEF-1:0] coe_t;

endpackage

// File: rtl/brightness_ctrl.sv
// Frame-synchronous sequencer for the brightness filter coefficient.
// Accepts a target/step/period over a valid-ready handshake and ramps the
// registered coefficient toward the target, changing it only on rising
// edges of vertical sync so the filter never sees a mid-frame gain change.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   cfg_valid_i     - config request valid (held until accepted)
//   cfg_ready_o     - high while idle; request accepted when both high
//   cfg_target_i    - unsigned target coefficient
//   cfg_step_i      - change per step, 0 jumps straight to target
//   cfg_period_i    - frames per step, 0 behaves as 1
//   vs_i            - vertical sync, active high
//   coe_o           - registered coefficient to the filter
//   busy_o          - ramp in progress
//   done_o          - one-cycle pulse when coe_o reaches target
module brightness_ctrl
    import brightness_pkg::*;
#(
    parameter int COE_WIDTH    = COE_WIDTH_DEF,
    parameter int STEP_WIDTH   = 8,
    parameter int PERIOD_WIDTH = 8,
    parameter int COE_UNITY    = COE_UNITY_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [COE_WIDTH-1:0]    cfg_target_i,
    input  logic [STEP_WIDTH-1:0]   cfg_step_i,
    input  logic [PERIOD_WIDTH-1:0] cfg_period_i,
    input  logic                    vs_i,
    output logic [COE_WIDTH-1:0]    coe_o,
    output logic                    busy_o,
    output logic                    done_o
);

    // One step toward the target. The difference is taken one bit wider and
    // signed so neither direction can wrap; when the remaining distance is no
    // larger than the step the result lands exactly on the target.
    function automatic logic [COE_WIDTH-1:0] f_step_toward(
        input logic [COE_WIDTH-1:0]  cur,
        input logic [COE_WIDTH-1:0]  tgt,
        input logic [STEP_WIDTH-1:0] step
    );
        logic signed [COE_WIDTH:0] diff;
        logic        [COE_WIDTH:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[COE_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        if ((step == '0) || (mag <= {{(COE_WIDTH+1-STEP_WIDTH){1'b0}}, step}))
            return tgt;
        else if (diff[COE_WIDTH])
            return cur - COE_WIDTH'(step);
        else
            return cur + COE_WIDTH'(step);
    endfunction

    state_t                  r_state;
    logic [COE_WIDTH-1:0]    r_coe;
    logic [COE_WIDTH-1:0]    r_target;
    logic [STEP_WIDTH-1:0]   r_step;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [PERIOD_WIDTH-1:0] r_frame_cnt;
    logic                    r_vs_d;
    logic                    r_done;

    logic                    w_vs_rise;
    logic                    w_accept;
    logic                    w_period_end;
    logic [COE_WIDTH-1:0]    w_next_coe;

    assign w_vs_rise    = vs_i & ~r_vs_d;
    assign w_accept     = cfg_valid_i & (r_state == ST_IDLE);
    assign w_period_end = (r_frame_cnt == (r_period - PERIOD_WIDTH'(1)));
    assign w_next_coe   = f_step_toward(r_coe, r_target, r_step);

    // Latched request parameters: plain data, loaded on accept only.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_target <= cfg_target_i;
            r_step   <= cfg_step_i;
            r_period <= (cfg_period_i == '0) ? PERIOD_WIDTH'(1) : cfg_period_i;
        end
    end

    // Sequencer state, frame counter, coefficient and sync edge history.
    // vs history resets high so a sync already high at reset release is not
    // mistaken for a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_coe       <= COE_WIDTH'(COE_UNITY);
            r_frame_cnt <= '0;
            r_vs_d      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_vs_d <= vs_i;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (cfg_target_i == r_coe) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= ST_RAMP;
                            r_frame_cnt <= '0;
                        end
                    end
                end
                ST_RAMP: begin
                    if (w_vs_rise) begin
                        if (w_period_end) begin
                            r_frame_cnt <= '0;
                            r_coe       <= w_next_coe;
                            if (w_next_coe == r_target) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_frame_cnt <= r_frame_cnt + PERIOD_WIDTH'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state == ST_RAMP);
    assign coe_o       = r_coe;
    assign done_o      = r_done;

endmodule

// File: tb/tb_brightness_ctrl.sv
module tb_brightness_ctrl;
    import brightness_pkg::*;

    logic       clk;
    logic       rst;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    coe_t       cfg_target_i;
    logic [7:0] cfg_step_i;
    logic [7:0] cfg_period_i;
    logic       vs_i;
    coe_t       coe_o;
    logic       busy_o;
    logic       done_o;

    int n_cmp = 0;
    int n_bad = 0;

    brightness_ctrl #(
        .COE_WIDTH   (16),
        .STEP_WIDTH  (8),
        .PERIOD_WIDTH(8),
        .COE_UNITY   (128)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_target_i(cfg_target_i),
        .cfg_step_i  (cfg_step_i),
        .cfg_period_i(cfg_period_i),
        .vs_i        (vs_i),
        .coe_o       (coe_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("%s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic vs_hi();
        vs_i = 1'b1;
        tick();
    endtask

    task automatic vs_lo();
        vs_i = 1'b0;
        tick();
    endtask

    task automatic vs_frame();
        vs_hi();
        vs_lo();
    endtask

    task automatic send_cfg(input logic [15:0] tgt, input logic [7:0] step, input logic [7:0] per);
        cfg_valid_i  = 1'b1;
        cfg_target_i = tgt;
        cfg_step_i   = step;
        cfg_period_i = per;
        tick();
        cfg_valid_i  = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        vs_i         = 1'b1;
        cfg_valid_i  = 1'b0;
        cfg_target_i = '0;
        cfg_step_i   = '0;
        cfg_period_i = '0;
        tick();
        tick();

        // Reset released while vs_i is still high.
        rst = 1'b0;
        tick();
        chk("rst_coe", coe_o, 128);
        chk("rst_ready", cfg_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        tick();
        chk("vs_high_no_edge", coe_o, 128);
        vs_lo();
        vs_hi();
        chk("idle_rise_coe", coe_o, 128);
        chk("idle_rise_busy", busy_o, 0);
        chk("idle_rise_done", done_o, 0);
        vs_lo();

        // Ramp up 128 -> 160, step 8, two frames per step.
        send_cfg(16'd160, 8'd8, 8'd2);
        chk("up_accept_busy", busy_o, 1);
        chk("up_accept_ready", cfg_ready_o, 0);
        chk("up_accept_coe", coe_o, 128);
        vs_frame();
        chk("up_r1", coe_o, 128);
        vs_frame();
        chk("up_r2", coe_o, 136);
        // A new request held during the ramp must not be taken.
        cfg_valid_i  = 1'b1;
        cfg_target_i = 16'd50;
        cfg_step_i   = 8'd0;
        cfg_period_i = 8'd1;
        vs_frame();
        chk("held_ready_low", cfg_ready_o, 0);
        chk("up_r3", coe_o, 136);
        vs_frame();
        chk("up_r4", coe_o, 144);
        vs_frame();
        vs_frame();
        chk("up_r6", coe_o, 152);
        chk("up_r6_done", done_o, 0);
        vs_frame();
        vs_hi();
        chk("up_r8_coe", coe_o, 160);
        chk("up_r8_done", done_o, 1);
        chk("up_r8_busy", busy_o, 0);
        chk("up_r8_ready", cfg_ready_o, 1);
        // Held request is accepted on the cycle ready is high.
        vs_lo();
        chk("held_accept_busy", busy_o, 1);
        chk("held_accept_done", done_o, 0);
        chk("held_accept_coe", coe_o, 160);
        cfg_valid_i = 1'b0;
        vs_hi();
        chk("held_jump_coe", coe_o, 50);
        chk("held_jump_done", done_o, 1);
        vs_lo();
        chk("held_done_clear", done_o, 0);

        // Reset in the middle of a ramp abandons it silently.
        send_cfg(16'd1000, 8'd1, 8'd1);
        vs_frame();
        chk("abort_r1", coe_o, 51);
        vs_frame();
        chk("abort_r2", coe_o, 52);
        rst = 1'b1;
        tick();
        chk("abort_coe", coe_o, 128);
        chk("abort_busy", busy_o, 0);
        chk("abort_ready", cfg_ready_o, 1);
        chk("abort_done", done_o, 0);
        rst = 1'b0;
        tick();
        chk("abort_done_after", done_o, 0);
        chk("abort_coe_after", coe_o, 128);

        // Ramp down 128 -> 100, step 10, period 0 behaves as 1.
        send_cfg(16'd100, 8'd10, 8'd0);
        vs_frame();
        chk("dn_r1", coe_o, 118);
        vs_frame();
        chk("dn_r2", coe_o, 108);
        vs_hi();
        chk("dn_r3_coe", coe_o, 100);
        chk("dn_r3_done", done_o, 1);
        vs_lo();
        chk("dn_done_clear", done_o, 0);

        // Jump with step 0.
        send_cfg(16'd200, 8'd0, 8'd1);
        chk("jump_pre", coe_o, 100);
        vs_hi();
        chk("jump_coe", coe_o, 200);
        chk("jump_done", done_o, 1);
        vs_lo();

        // Same target again: immediate done, no vs needed.
        send_cfg(16'd200, 8'd5, 8'd3);
        chk("noop_done", done_o, 1);
        chk("noop_busy", busy_o, 0);
        chk("noop_coe", coe_o, 200);
        tick();
        chk("noop_done_clear", done_o, 0);

        // Maximum period, landing on target 0.
        send_cfg(16'd0, 8'd255, 8'd255);
        for (int i = 0; i < 254; i++) vs_frame();
        chk("pmax_hold_coe", coe_o, 200);
        chk("pmax_hold_busy", busy_o, 1);
        vs_hi();
        chk("pmax_coe", coe_o, 0);
        chk("pmax_done", done_o, 1);
        vs_lo();

        // Top of range and near-top clamp without wrap.
        send_cfg(16'hFFFF, 8'd0, 8'd1);
        vs_frame();
        chk("top_coe", coe_o, 65535);
        send_cfg(16'd65500, 8'd100, 8'd1);
        vs_hi();
        chk("near_top_coe", coe_o, 65500);
        chk("near_top_done", done_o, 1);
        vs_lo();

        // Bottom of range without underflow.
        send_cfg(16'd30, 8'd0, 8'd1);
        vs_frame();
        chk("low_jump", coe_o, 30);
        send_cfg(16'd0, 8'd20, 8'd1);
        vs_frame();
        chk("bot_r1", coe_o, 10);
        vs_hi();
        chk("bot_r2_coe", coe_o, 0);
        chk("bot_r2_done", done_o, 1);
        vs_lo();
        chk("bot_idle", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
